// File: rtl/axi_aw_burst_issuer.sv
// Pops {len_beats, addr} write commands from the awaddr prefetch FIFO and issues them on the
// AXI AW channel as INCR bursts capped at MAX_BURST beats that never cross a 4 KB page.
module axi_aw_burst_issuer #(
    parameter int         ADDR_WIDTH = 28,
    parameter int         LEN_WIDTH  = 16,
    parameter int         DATA_BYTES = 32,
    parameter int         MAX_BURST  = 16,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [LEN_WIDTH+ADDR_WIDTH-1:0] fifo_rd_data,
    input  logic                            fifo_rd_vld,
    output logic                            fifo_rd_en,
    output logic [3:0]                      axi_awid,
    output logic [ADDR_WIDTH-1:0]           axi_awaddr,
    output logic [7:0]                      axi_awlen,
    output logic [2:0]                      axi_awsize,
    output logic [1:0]                      axi_awburst,
    output logic                            axi_awvalid,
    input  logic                            axi_awready,
    output logic                            cmd_done,
    output logic                            busy,
    output logic [1:0]                      state_dbg
);

    localparam int SZ = $clog2(DATA_BYTES);
    // Wide enough for the full command length plus one and for the constant 4096.
    localparam int CW = (LEN_WIDTH + 1 > 14) ? LEN_WIDTH + 1 : 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [CW-1:0]           rem;
    logic [CW-1:0]           burst;
    logic [CW-1:0]           b2k;
    logic [CW-1:0]           burst_calc;
    logic [CW-1:0]           rem_after;
    logic [LEN_WIDTH-1:0]    cmd_len;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [ADDR_WIDTH-1:0]   addr_mask;
    logic [ADDR_WIDTH-1:0]   addr_step;
    logic                    pop;

    // FIFO handshake: a command is consumed on any cycle with fifo_rd_vld & fifo_rd_en.
    // AW handshake: axi_awaddr/axi_awlen are held while axi_awvalid is high until axi_awready.
    assign cmd_len    = fifo_rd_data[LEN_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
    assign cmd_addr   = fifo_rd_data[ADDR_WIDTH-1:0];
    assign fifo_rd_en = rst_n && (state == IDLE);
    assign pop        = fifo_rd_vld && fifo_rd_en;
    assign addr_mask  = ~ADDR_WIDTH'((1 << SZ) - 1);

    // Beats left before the next 4 KB page; a page-aligned address yields a full page.
    assign b2k = (CW'(4096) - CW'(cur_addr[11:0])) >> SZ;

    always_comb begin
        burst_calc = rem;
        if (burst_calc > CW'(MAX_BURST)) begin
            burst_calc = CW'(MAX_BURST);
        end
        if (burst_calc > b2k) begin
            burst_calc = b2k;
        end
    end

    assign rem_after = rem - burst;
    assign addr_step = ADDR_WIDTH'(burst) << SZ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            rem         <= '0;
            burst       <= '0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awvalid <= 1'b0;
            cmd_done    <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_addr <= cmd_addr & addr_mask;
                        rem      <= CW'(cmd_len);
                        if (cmd_len == '0) begin
                            cmd_done <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    burst       <= burst_calc;
                    axi_awaddr  <= cur_addr;
                    axi_awlen   <= 8'(burst_calc - CW'(1));
                    axi_awvalid <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (axi_awvalid && axi_awready) begin
                        axi_awvalid <= 1'b0;
                        cur_addr    <= cur_addr + addr_step;
                        rem         <= rem_after;
                        if (rem_after == '0) begin
                            cmd_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    axi_awvalid <= 1'b0;
                end
            endcase
        end
    end

    assign axi_awid    = AXI_ID;
    assign axi_awsize  = 3'(SZ);
    assign axi_awburst = 2'b01;
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_axi_aw_burst_issuer.sv
// Bench for axi_aw_burst_issuer: directed and random commands checked against a
// page/burst splitting model computed with plain arithmetic.
module tb_axi_aw_burst_issuer;

    localparam int AW = 28;
    localparam int LW = 16;
    localparam int DB = 32;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW+AW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_vld = 1'b0;
    logic          fifo_rd_en;
    logic [3:0]    axi_awid;
    logic [AW-1:0] axi_awaddr;
    logic [7:0]    axi_awlen;
    logic [2:0]    axi_awsize;
    logic [1:0]    axi_awburst;
    logic          axi_awvalid;
    logic          axi_awready = 1'b0;
    logic          cmd_done;
    logic          busy;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_len_q[$];

    always #5 clk = ~clk;

    axi_aw_burst_issuer #(
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .DATA_BYTES (DB),
        .MAX_BURST  (MB),
        .AXI_ID     (4'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_en   (fifo_rd_en),
        .axi_awid     (axi_awid),
        .axi_awaddr   (axi_awaddr),
        .axi_awlen    (axi_awlen),
        .axi_awsize   (axi_awsize),
        .axi_awburst  (axi_awburst),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .cmd_done     (cmd_done),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the command in bursts limited by remaining beats, MAX_BURST and the page end.
    task automatic model_cmd(input int len, input logic [AW-1:0] addr);
        longint a;
        int     rem;
        int     b;
        int     room;
        a   = longint'(addr) & ~longint'(DB - 1);
        rem = len;
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / DB;
            b = rem;
            if (b > MB) b = MB;
            if (b > room) b = room;
            exp_addr_q.push_back(AW'(a));
            exp_len_q.push_back(8'(b - 1));
            a   = (a + longint'(b * DB)) % (longint'(1) << AW);
            rem -= b;
        end
    endtask

    task automatic run_cmd(input int len, input logic [AW-1:0] addr, input int ready_pct, input int hold);
        int   nb;
        int   cyc;
        int   hs;
        int   hold_left;
        logic pending;
        model_cmd(len, addr);
        nb = exp_addr_q.size();
        fifo_rd_data = {LW'(len), addr};
        fifo_rd_vld  = 1'b1;
        cyc = 0;
        while (fifo_rd_en !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("pop_ready", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        fifo_rd_vld  = 1'b0;
        fifo_rd_data = {16'($urandom), 28'($urandom)};
        if (nb == 0) begin
            check("zero_len_done", 32'(cmd_done), 32'd1);
            check("zero_len_busy", 32'(busy), 32'd0);
            check("zero_len_awvalid", 32'(axi_awvalid), 32'd0);
            @(negedge clk);
            check("zero_len_done_clear", 32'(cmd_done), 32'd0);
            return;
        end
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_awvalid", 32'(axi_awvalid), 32'd0);
        check("calc_rd_en", 32'(fifo_rd_en), 32'd0);
        cyc       = 1;
        hs        = 0;
        hold_left = hold;
        pending   = 1'b0;
        while (hs < nb && cyc < 400) begin
            check("done_early", 32'(cmd_done), 32'd0);
            check("busy_rd_en", 32'(fifo_rd_en), 32'd0);
            if (pending) check("awvalid_held", 32'(axi_awvalid), 32'd1);
            if (axi_awvalid === 1'b1) begin
                check("awaddr", 32'(axi_awaddr), 32'(exp_addr_q[0]));
                check("awlen", 32'(axi_awlen), 32'(exp_len_q[0]));
                check("awid", 32'(axi_awid), 32'd0);
                check("awsize", 32'(axi_awsize), 32'd5);
                check("awburst", 32'(axi_awburst), 32'd1);
                if (hold_left > 0) begin
                    axi_awready = 1'b0;
                    hold_left--;
                end else begin
                    axi_awready = ($urandom_range(99) < ready_pct);
                end
                if (axi_awready) begin
                    if (ready_pct == 100 && hold == 0) check("hs_cycle", 32'(cyc), 32'(2 + 2 * hs));
                    check("no_4k_cross",
                          32'((int'(axi_awaddr[11:0]) + (int'(axi_awlen) + 1) * DB) <= 4096), 32'd1);
                    void'(exp_addr_q.pop_front());
                    void'(exp_len_q.pop_front());
                    hs++;
                    pending = 1'b0;
                end else begin
                    pending = 1'b1;
                end
            end else begin
                axi_awready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        axi_awready = 1'b0;
        check("hs_count", 32'(hs), 32'(nb));
        check("done_pulse", 32'(cmd_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_awvalid", 32'(axi_awvalid), 32'd0);
        check("done_rd_en", 32'(fifo_rd_en), 32'd1);
        exp_addr_q.delete();
        exp_len_q.delete();
        @(negedge clk);
        check("done_clear", 32'(cmd_done), 32'd0);
    endtask

    initial begin
        int            cyc;
        int            len;
        logic [AW-1:0] addr;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_awvalid", 32'(axi_awvalid), 32'd0);
        check("rst_awaddr", 32'(axi_awaddr), 32'd0);
        check("rst_awlen", 32'(axi_awlen), 32'd0);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_rd_en", 32'(fifo_rd_en), 32'd1);

        run_cmd(40, 28'h0000000, 100, 0);   // three bursts 16/16/8
        run_cmd(8, 28'h0000F80, 100, 0);    // page split 4/4
        run_cmd(4, 28'h0000040, 100, 10);   // awready held low
        run_cmd(0, 28'h0000100, 100, 0);    // zero length
        run_cmd(1, 28'h0000200, 100, 0);
        run_cmd(2, 28'hFFFFFE0, 100, 0);    // address wrap

        // Reset while a burst is waiting on awready
        fifo_rd_data = {16'd40, 28'h0000000};
        fifo_rd_vld  = 1'b1;
        @(negedge clk);
        fifo_rd_vld = 1'b0;
        cyc = 0;
        while (axi_awvalid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_valid_before_rst", 32'(axi_awvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_awvalid", 32'(axi_awvalid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t6_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(5, 28'h0000300, 100, 0);

        // Random commands, many near page ends, with random awready
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(3) == 0) len = int'($urandom_range(3));
            else len = int'($urandom_range(80, 1));
            addr = 28'($urandom);
            if ($urandom_range(1) == 1) addr[11:0] = 12'(4096 - 32 * int'($urandom_range(8, 1)));
            run_cmd(len, addr, int'($urandom_range(100, 30)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
